// File: rtl/pic_core_pkg.sv
// Shared definitions for the PIC-style core: INTCON bit map, interrupt vector,
// interrupt FSM states and special-register reset values.
package pic_core_pkg;

  localparam int GIE_BIT  = 7;
  localparam int PEIE_BIT = 6;
  localparam int T0IE_BIT = 5;
  localparam int INTE_BIT = 4;
  localparam int RBIE_BIT = 3;
  localparam int T0IF_BIT = 2;
  localparam int INTF_BIT = 1;
  localparam int RBIF_BIT = 0;

  localparam logic [12:0] ISR_VECTOR = 13'h0004;

  localparam logic [7:0] INTCON_RST = 8'h00;
  localparam logic [7:0] PIE1_RST   = 8'h00;
  localparam logic [7:0] PIR1_RST   = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    VECTOR,
    IN_ISR
  } int_state_t;

  // Any enabled source with its flag set, independent of GIE.
  function automatic logic irq_term(input logic [7:0] intcon,
                                    input logic [7:0] pie1,
                                    input logic [7:0] pir1);
    return (intcon[T0IE_BIT] & intcon[T0IF_BIT]) |
           (intcon[INTE_BIT] & intcon[INTF_BIT]) |
           (intcon[RBIE_BIT] & intcon[RBIF_BIT]) |
           (intcon[PEIE_BIT] & (|(pie1 & pir1)));
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Register-file and sequencer handshake between the core and the interrupt controller.
interface interrupt_controller_if;
  logic       intcon_wr_en;
  logic [7:0] intcon_in;
  logic [7:0] intcon_out;
  logic       pie1_wr_en;
  logic [7:0] pie1_in;
  logic [7:0] pie1_out;
  logic       pir1_wr_en;
  logic [7:0] pir1_in;
  logic [7:0] pir1_out;
  logic       instr_boundary;
  logic       retfie_en;
  logic       pc_j_to_isr;
  logic       isr_active;

  modport master (
    output intcon_wr_en, intcon_in, pie1_wr_en, pie1_in, pir1_wr_en, pir1_in,
    output instr_boundary, retfie_en,
    input  intcon_out, pie1_out, pir1_out, pc_j_to_isr, isr_active
  );

  modport slave (
    input  intcon_wr_en, intcon_in, pie1_wr_en, pie1_in, pir1_wr_en, pir1_in,
    input  instr_boundary, retfie_en,
    output intcon_out, pie1_out, pir1_out, pc_j_to_isr, isr_active
  );
endinterface

// File: rtl/pin_sync_edge.sv
// Synchronises the asynchronous INT pin and produces a one-cycle edge pulse whose
// polarity follows intedg; the detector stays disarmed until the chain has filled.
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic intedg,
  output logic edge_pulse
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       arm_cnt_q;
  logic                   armed;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_cnt_q == CNT_W'(ARM_CYCLES));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= synced;
      if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
    end
  end

  // Reset-cleared chain looks like a rising edge if the pin is already high; arming masks it.
  assign edge_pulse = armed & (intedg ? (synced & ~prev_q) : (~synced & prev_q));

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: INTCON/PIE1/PIR1 flag registers, pending logic and the
// vector/ISR tracking FSM that drives pc_j_to_isr into the program counter.
module interrupt_controller
  import pic_core_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_PERIPH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_controller_if.slave  bus,
  input  logic                   intedg,
  input  logic                   int_pin,
  input  logic                   t0_ovf,
  input  logic                   rb_change,
  input  logic [NUM_PERIPH-1:0]  periph_irq,
  output logic                   wake
);

  logic [7:0] intcon_q, intcon_nxt;
  logic [7:0] pie1_q, pie1_nxt;
  logic [7:0] pir1_q, pir1_nxt;
  logic [7:0] periph_set;
  logic       int_edge;
  logic       irq_any;
  logic       pend;
  logic       pc_j_q;
  int_state_t state_q, state_nxt;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .pin        (int_pin),
    .intedg     (intedg),
    .edge_pulse (int_edge)
  );

  assign periph_set = 8'(periph_irq);

  // Hardware events are applied after the software write so they win a same-cycle clear;
  // RETFIE is applied last so GIE always ends at 1.
  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    intcon_nxt = intcon_q;
    if (bus.intcon_wr_en) intcon_nxt = bus.intcon_in;
    if (t0_ovf)           intcon_nxt[T0IF_BIT] = 1'b1;
    if (int_edge)         intcon_nxt[INTF_BIT] = 1'b1;
    if (rb_change)        intcon_nxt[RBIF_BIT] = 1'b1;
    if (state_q == VECTOR) intcon_nxt[GIE_BIT] = 1'b0;
    if (bus.retfie_en)    intcon_nxt[GIE_BIT] = 1'b1;

    pie1_nxt = bus.pie1_wr_en ? bus.pie1_in : pie1_q;
    pir1_nxt = (bus.pir1_wr_en ? bus.pir1_in : pir1_q) | periph_set;
  end

  assign irq_any = irq_term(intcon_q, pie1_q, pir1_q);
  assign pend    = intcon_q[GIE_BIT] & irq_any;
  assign wake    = irq_any;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (pend) state_nxt = ARMED;
      ARMED:   if (!pend) state_nxt = IDLE;
               else if (bus.instr_boundary) state_nxt = VECTOR;
      VECTOR:  state_nxt = IN_ISR;
      IN_ISR:  if (bus.retfie_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intcon_q <= INTCON_RST;
      pie1_q   <= PIE1_RST;
      pir1_q   <= PIR1_RST;
      state_q  <= IDLE;
      pc_j_q   <= 1'b0;
    end else begin
      intcon_q <= intcon_nxt;
      pie1_q   <= pie1_nxt;
      pir1_q   <= pir1_nxt;
      state_q  <= state_nxt;
      pc_j_q   <= (state_nxt == VECTOR);
    end
  end

  assign bus.intcon_out  = intcon_q;
  assign bus.pie1_out    = pie1_q;
  assign bus.pir1_out    = pir1_q;
  assign bus.pc_j_to_isr = pc_j_q;
  assign bus.isr_active  = (state_q == VECTOR) || (state_q == IN_ISR);

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios against constants plus randomized
// traffic against a cycle-level behavioural model of the interrupt rules.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       intedg, int_pin, t0_ovf, rb_change, wake;
  logic [7:0] periph_irq;

  interrupt_controller_if bus();

  interrupt_controller #(.SYNC_STAGES(2), .NUM_PERIPH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .intedg     (intedg),
    .int_pin    (int_pin),
    .t0_ovf     (t0_ovf),
    .rb_change  (rb_change),
    .periph_irq (periph_irq),
    .wake       (wake)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: register images, ISR bookkeeping, pin samples since reset.
  logic [7:0] m_intcon, m_pie1, m_pir1;
  bit         m_armed, m_vec, m_isr;
  bit         m_pins[$];
  bit         auto_bnd;
  int         cyc;

  function automatic bit m_irq(input logic [7:0] ic, input logic [7:0] pe, input logic [7:0] pr);
    return (ic[5] & ic[2]) | (ic[4] & ic[1]) | (ic[3] & ic[0]) | (ic[6] & (|(pe & pr)));
  endfunction

  function bit pin_at(input int k);
    if (k < 1 || k > m_pins.size()) return 1'b0;
    return m_pins[k-1];
  endfunction

  task model_reset;
    m_intcon = 8'h00; m_pie1 = 8'h00; m_pir1 = 8'h00;
    m_armed = 0; m_vec = 0; m_isr = 0;
    m_pins.delete();
  endtask

  // One clock edge: pin edge seen two samples back becomes INTF now, once 4+ edges since reset.
  task model_step;
    int         m;
    bit         intf_evt, pend_old, nv, na, ni, idle;
    logic [7:0] ic;
    pend_old = m_intcon[7] & m_irq(m_intcon, m_pie1, m_pir1);
    m = m_pins.size() + 1;
    intf_evt = (m >= 4) && (intedg ? (pin_at(m-2) && !pin_at(m-3))
                                   : (!pin_at(m-2) && pin_at(m-3)));
    m_pins.push_back(int_pin);
    ic = bus.intcon_wr_en ? bus.intcon_in : m_intcon;
    if (t0_ovf)    ic[2] = 1'b1;
    if (intf_evt)  ic[1] = 1'b1;
    if (rb_change) ic[0] = 1'b1;
    if (m_vec)     ic[7] = 1'b0;
    if (bus.retfie_en) ic[7] = 1'b1;
    idle = !m_armed && !m_vec && !m_isr;
    nv = m_armed && pend_old && bus.instr_boundary;
    na = pend_old && (idle || (m_armed && !bus.instr_boundary));
    ni = m_vec || (m_isr && !bus.retfie_en);
    m_intcon = ic;
    m_pie1   = bus.pie1_wr_en ? bus.pie1_in : m_pie1;
    m_pir1   = (bus.pir1_wr_en ? bus.pir1_in : m_pir1) | periph_irq;
    m_vec = nv; m_armed = na; m_isr = ni;
  endtask

  task tick;
    if (auto_bnd) bus.instr_boundary = (cyc % 4 == 3);
    cyc++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task drive_idle;
    bus.intcon_wr_en = 0; bus.intcon_in = 8'h00;
    bus.pie1_wr_en = 0;   bus.pie1_in = 8'h00;
    bus.pir1_wr_en = 0;   bus.pir1_in = 8'h00;
    bus.instr_boundary = 0; bus.retfie_en = 0;
    t0_ovf = 0; rb_change = 0; periph_irq = 8'h00;
  endtask

  task do_reset(input bit pin_level);
    rst = 1'b0;
    drive_idle();
    intedg = 1'b0; int_pin = pin_level;
    auto_bnd = 0; cyc = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task write_intcon(input logic [7:0] v);
    bus.intcon_wr_en = 1; bus.intcon_in = v;
    tick();
    bus.intcon_wr_en = 0;
  endtask

  task wait_vector(input int budget, output int lat, output bit seen);
    lat = 0; seen = 0;
    while (!seen && lat < budget) begin
      tick();
      lat++;
      if (bus.pc_j_to_isr) seen = 1;
    end
  endtask

  task test_reset;
    int lat; bit seen;
    do_reset(1'b0);
    checks++;
    if ({bus.pc_j_to_isr, bus.isr_active, wake} !== 3'b000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=000", {bus.pc_j_to_isr, bus.isr_active, wake});
    end
    checks++;
    if ({bus.intcon_out, bus.pie1_out, bus.pir1_out} !== 24'h0) begin
      failures++; $display("FAIL reset_regs got=%h exp=000000", {bus.intcon_out, bus.pie1_out, bus.pir1_out});
    end
    auto_bnd = 1;
    bus.pie1_wr_en = 1; bus.pie1_in = 8'h5A; tick(); bus.pie1_wr_en = 0;
    write_intcon(8'hA4);
    wait_vector(16, lat, seen);
    tick();
    checks++;
    if (bus.isr_active !== 1'b1) begin
      failures++; $display("FAIL reset_setup_isr got=%b exp=1", bus.isr_active);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.pc_j_to_isr, bus.isr_active, wake} !== 3'b000) begin
      failures++; $display("FAIL reset_mid_isr_outputs got=%b exp=000", {bus.pc_j_to_isr, bus.isr_active, wake});
    end
    checks++;
    if ({bus.intcon_out, bus.pie1_out, bus.pir1_out} !== 24'h0) begin
      failures++; $display("FAIL reset_mid_isr_regs got=%h exp=000000", {bus.intcon_out, bus.pie1_out, bus.pir1_out});
    end
  endtask

  task test_timer;
    int lat; bit seen;
    do_reset(1'b0);
    auto_bnd = 1;
    write_intcon(8'hA0);
    t0_ovf = 1; tick(); t0_ovf = 0;
    checks++;
    if (bus.intcon_out !== 8'hA4) begin
      failures++; $display("FAIL timer_t0if got=%h exp=a4", bus.intcon_out);
    end
    wait_vector(12, lat, seen);
    checks++;
    if (!seen || lat < 2 || lat > 5) begin
      failures++; $display("FAIL timer_latency got=seen%0d/lat%0d exp=seen1/lat2..5", seen, lat);
    end
    tick();
    checks++;
    if ({bus.pc_j_to_isr, bus.isr_active, bus.intcon_out} !== {2'b01, 8'h24}) begin
      failures++; $display("FAIL timer_in_isr got=%b/%b/%h exp=0/1/24", bus.pc_j_to_isr, bus.isr_active, bus.intcon_out);
    end
    bus.retfie_en = 1; tick(); bus.retfie_en = 0;
    checks++;
    if ({bus.isr_active, bus.intcon_out} !== {1'b0, 8'hA4}) begin
      failures++; $display("FAIL timer_retfie got=%b/%h exp=0/a4", bus.isr_active, bus.intcon_out);
    end
  endtask

  task test_int_pin;
    int lat; bit seen;
    do_reset(1'b1);
    auto_bnd = 1;
    write_intcon(8'h90);
    repeat (6) tick();
    checks++;
    if (bus.intcon_out !== 8'h90) begin
      failures++; $display("FAIL pin_held_high_no_intf got=%h exp=90", bus.intcon_out);
    end
    int_pin = 1'b0;
    tick(); tick();
    checks++;
    if (bus.intcon_out[1] !== 1'b0) begin
      failures++; $display("FAIL pin_intf_early got=%b exp=0", bus.intcon_out[1]);
    end
    tick();
    checks++;
    if (bus.intcon_out[1] !== 1'b1) begin
      failures++; $display("FAIL pin_intf_plus3 got=%b exp=1", bus.intcon_out[1]);
    end
    wait_vector(12, lat, seen);
    checks++;
    if (!seen) begin
      failures++; $display("FAIL pin_vector got=0 exp=1");
    end
  endtask

  task test_cancel;
    int n;
    do_reset(1'b0);
    bus.instr_boundary = 0;
    write_intcon(8'hA4);
    repeat (3) tick();
    checks++;
    if ({bus.pc_j_to_isr, bus.isr_active} !== 2'b00) begin
      failures++; $display("FAIL cancel_waiting got=%b exp=00", {bus.pc_j_to_isr, bus.isr_active});
    end
    write_intcon(8'h24);
    auto_bnd = 1; n = 0;
    repeat (10) begin tick(); if (bus.pc_j_to_isr) n++; end
    checks++;
    if (n != 0 || bus.intcon_out !== 8'h24) begin
      failures++; $display("FAIL cancel_no_vector got=%0d/%h exp=0/24", n, bus.intcon_out);
    end
  endtask

  task test_periph;
    int n, lat; bit seen;
    do_reset(1'b0);
    auto_bnd = 1;
    bus.pie1_wr_en = 1; bus.pie1_in = 8'h01; tick(); bus.pie1_wr_en = 0;
    periph_irq = 8'h01; tick(); periph_irq = 8'h00;
    checks++;
    if ({bus.pir1_out, wake} !== {8'h01, 1'b0}) begin
      failures++; $display("FAIL periph_flag got=%h/%b exp=01/0", bus.pir1_out, wake);
    end
    n = 0;
    repeat (8) begin tick(); if (bus.pc_j_to_isr) n++; end
    checks++;
    if (n != 0) begin
      failures++; $display("FAIL periph_no_peie got=%0d exp=0", n);
    end
    write_intcon(8'hC0);
    wait_vector(12, lat, seen);
    checks++;
    if (!seen) begin
      failures++; $display("FAIL periph_vector got=0 exp=1");
    end
  endtask

  task test_collisions;
    int lat; bit seen;
    do_reset(1'b0);
    auto_bnd = 1;
    rb_change = 1; bus.intcon_wr_en = 1; bus.intcon_in = 8'h00;
    tick();
    rb_change = 0; bus.intcon_wr_en = 0;
    checks++;
    if (bus.intcon_out !== 8'h01) begin
      failures++; $display("FAIL rbif_beats_write got=%h exp=01", bus.intcon_out);
    end
    bus.retfie_en = 1; tick(); bus.retfie_en = 0;
    checks++;
    if ({bus.isr_active, bus.intcon_out} !== {1'b0, 8'h81}) begin
      failures++; $display("FAIL retfie_outside_isr got=%b/%h exp=0/81", bus.isr_active, bus.intcon_out);
    end
    write_intcon(8'hA4);
    wait_vector(12, lat, seen);
    tick();
    bus.retfie_en = 1; bus.intcon_wr_en = 1; bus.intcon_in = 8'h20;
    tick();
    bus.retfie_en = 0; bus.intcon_wr_en = 0;
    checks++;
    if ({seen, bus.isr_active, bus.intcon_out} !== {2'b10, 8'hA0}) begin
      failures++; $display("FAIL retfie_with_write got=%b/%b/%h exp=1/0/a0", seen, bus.isr_active, bus.intcon_out);
    end
  endtask

  task test_random;
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      bus.intcon_wr_en = ($urandom % 10 == 0); bus.intcon_in = 8'($urandom);
      bus.pie1_wr_en   = ($urandom % 12 == 0); bus.pie1_in   = 8'($urandom);
      bus.pir1_wr_en   = ($urandom % 12 == 0); bus.pir1_in   = 8'($urandom);
      t0_ovf     = ($urandom % 16 == 0);
      rb_change  = ($urandom % 16 == 0);
      periph_irq = ($urandom % 8 == 0) ? (8'h01 << ($urandom % 8)) : 8'h00;
      bus.instr_boundary = ($urandom % 3 == 0);
      bus.retfie_en      = ($urandom % 12 == 0);
      if ($urandom % 8 == 0)  int_pin = ~int_pin;
      if ($urandom % 32 == 0) intedg  = ~intedg;
      tick();
      checks++;
      if (bus.pc_j_to_isr !== m_vec) begin
        failures++; $display("FAIL rand_pc_j cyc=%0d got=%b exp=%b", i, bus.pc_j_to_isr, m_vec);
      end
      checks++;
      if (bus.isr_active !== (m_vec | m_isr)) begin
        failures++; $display("FAIL rand_isr_active cyc=%0d got=%b exp=%b", i, bus.isr_active, m_vec | m_isr);
      end
      checks++;
      if (wake !== m_irq(m_intcon, m_pie1, m_pir1)) begin
        failures++; $display("FAIL rand_wake cyc=%0d got=%b exp=%b", i, wake, m_irq(m_intcon, m_pie1, m_pir1));
      end
      checks++;
      if ({bus.intcon_out, bus.pie1_out, bus.pir1_out} !== {m_intcon, m_pie1, m_pir1}) begin
        failures++; $display("FAIL rand_regs cyc=%0d got=%h exp=%h", i,
                             {bus.intcon_out, bus.pie1_out, bus.pir1_out}, {m_intcon, m_pie1, m_pir1});
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_timer();
    test_int_pin();
    test_cancel();
    test_periph();
    test_collisions();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
